// File: rtl/ro_measure_scheduler.sv
// Time-multiplexed ring-oscillator frequency measurement: one shared, saturating
// edge counter is scheduled between the internal and external rings over fixed gate windows.
module ro_measure_scheduler #(
    parameter int GATE_CYCLES   = 200,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       enable,
    input  logic       RO_internal,
    input  logic       RO_external,
    input  logic [7:0] Fro_min,
    output logic       ring_on,
    output logic       sel,
    output logic [7:0] count_internal,
    output logic [7:0] count_external,
    output logic       valid,
    output logic       Fail
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE_INT,
        GATE_INT,
        SETTLE_EXT,
        GATE_EXT,
        REPORT
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   timer, timer_next;
    logic [7:0]      cnt, cnt_next, cnt_inc;
    logic [2:0]      int_sync, ext_sync;
    logic            edge_sel;
    logic            latch_int, latch_ext, report;

    // [1:0] is the synchronizer pair, [2] holds the previous value for edge detection.
    assign edge_sel = sel ? (ext_sync[1] & ~ext_sync[2]) : (int_sync[1] & ~int_sync[2]);
    assign cnt_inc  = (edge_sel && cnt != 8'hFF) ? cnt + 8'd1 : cnt;

    always_comb begin
        state_next = state;
        timer_next = timer;
        cnt_next   = cnt;
        latch_int  = 1'b0;
        latch_ext  = 1'b0;
        report     = 1'b0;
        ring_on    = 1'b1;
        sel        = 1'b0;
        valid      = 1'b0;
        unique case (state)
            IDLE: begin
                ring_on    = 1'b0;
                timer_next = '0;
                cnt_next   = '0;
                if (enable) state_next = SETTLE_INT;
            end
            SETTLE_INT: begin
                cnt_next = '0;
                if (timer == SETTLE_LAST) begin
                    timer_next = '0;
                    state_next = GATE_INT;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            GATE_INT: begin
                cnt_next = cnt_inc;
                if (timer == GATE_LAST) begin
                    timer_next = '0;
                    latch_int  = 1'b1;
                    state_next = SETTLE_EXT;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            SETTLE_EXT: begin
                sel      = 1'b1;
                cnt_next = '0;
                if (timer == SETTLE_LAST) begin
                    timer_next = '0;
                    state_next = GATE_EXT;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            GATE_EXT: begin
                sel      = 1'b1;
                cnt_next = cnt_inc;
                if (timer == GATE_LAST) begin
                    timer_next = '0;
                    latch_ext  = 1'b1;
                    state_next = REPORT;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            REPORT: begin
                report     = 1'b1;
                valid      = 1'b1;
                timer_next = '0;
                cnt_next   = '0;
                state_next = enable ? SETTLE_INT : IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Dropping enable mid-round abandons it without touching the published results.
        if (!enable && state != IDLE && state != REPORT) begin
            state_next = IDLE;
            timer_next = '0;
            cnt_next   = '0;
            latch_int  = 1'b0;
            latch_ext  = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            timer          <= '0;
            cnt            <= '0;
            int_sync       <= '0;
            ext_sync       <= '0;
            count_internal <= '0;
            count_external <= '0;
            Fail           <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            cnt      <= cnt_next;
            int_sync <= {int_sync[1:0], RO_internal};
            ext_sync <= {ext_sync[1:0], RO_external};
            if (latch_int) count_internal <= cnt_inc;
            if (latch_ext) count_external <= cnt_inc;
            if (report)    Fail <= (count_internal < Fro_min) || (count_external < Fro_min);
        end
    end

endmodule

// File: tb/tb_ro_measure_scheduler.sv
// Bench for ro_measure_scheduler: round-schedule and ideal-edge-count model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_ro_measure_scheduler;

    localparam int S         = 16;
    localparam int G         = 200;
    localparam int ROUND     = 2 * (S + G) + 1;
    localparam int G_SAT     = 1000;
    localparam int ROUND_SAT = 2 * (S + G_SAT) + 1;
    localparam int CLK_NS    = 20;
    localparam int INT_NS    = 50;
    localparam int EXT_NS    = 100;
    localparam int BIG       = 32'h7fff_ffff;

    // clock / reset / stimulus signals
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       en_sat = 1'b0;
    logic       ext_on = 1'b1;
    logic       ro_int = 1'b0;
    logic       ro_ext_free = 1'b0;
    logic       ro_ext;
    logic [7:0] fro_min = 8'd0;
    logic [7:0] fro_min_sat = 8'd201;

    logic       ring_on, sel, valid, fail;
    logic [7:0] count_internal, count_external;
    logic       ring_on_sat, sel_sat, valid_sat, fail_sat;
    logic [7:0] count_internal_sat, count_external_sat;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // round-schedule model state, written by the stimulus process
    bit run = 1'b0;
    int run_n = 0;
    int run_m = BIG;
    bit sat_done = 1'b0;

    // scoreboard: expected Fail values, each due the cycle after a report
    logic [0:0] exp_q[$];
    logic       mdl_fail = 1'b0;

    assign ro_ext = ro_ext_free & ext_on;

    ro_measure_scheduler #(.GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
        .clk_50MHz      (clk),
        .rst            (rst),
        .enable         (enable),
        .RO_internal    (ro_int),
        .RO_external    (ro_ext),
        .Fro_min        (fro_min),
        .ring_on        (ring_on),
        .sel            (sel),
        .count_internal (count_internal),
        .count_external (count_external),
        .valid          (valid),
        .Fail           (fail)
    );

    ro_measure_scheduler #(.GATE_CYCLES(G_SAT), .SETTLE_CYCLES(S)) dut_sat (
        .clk_50MHz      (clk),
        .rst            (rst),
        .enable         (en_sat),
        .RO_internal    (ro_int),
        .RO_external    (ro_ext_free),
        .Fro_min        (fro_min_sat),
        .ring_on        (ring_on_sat),
        .sel            (sel_sat),
        .count_internal (count_internal_sat),
        .count_external (count_external_sat),
        .valid          (valid_sat),
        .Fail           (fail_sat)
    );

    // clock block; ring edges sit 3 ns off the 10 ns grid so they never meet a clock edge
    initial forever #(CLK_NS / 2) clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3;
        forever begin
            ro_int = 1'b1; #(INT_NS / 2);
            ro_int = 1'b0; #(INT_NS / 2);
        end
    end

    initial begin
        #3;
        forever begin
            ro_ext_free = 1'b1; #(EXT_NS / 2);
            ro_ext_free = 1'b0; #(EXT_NS / 2);
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // ideal edge count: the window length is a whole number of ring periods
    function automatic int ideal_count(input int gate, input int period, input bit on);
        int n;
        n = on ? (gate * CLK_NS) / period : 0;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic wait_valid(input int budget, input string name, output int vc);
        vc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid) begin
                vc = cyc;
                break;
            end
        end
        if (vc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no valid pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    // compare process
    int cmp_p;
    bit cmp_ring, cmp_valid, cmp_sel;
    int cmp_ci, cmp_ce;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_ring_on", int'(ring_on), 0);
                check("rst_sel", int'(sel), 0);
                check("rst_valid", int'(valid), 0);
                check("rst_fail", int'(fail), 0);
                check("rst_count_int", int'(count_internal), 0);
                check("rst_count_ext", int'(count_external), 0);
                exp_q.delete();
                mdl_fail = 1'b0;
            end else begin
                cmp_ring  = run && cyc > run_n && cyc <= run_m;
                cmp_valid = cmp_ring && ((cyc - run_n) % ROUND == 0);
                cmp_p     = cmp_ring ? (cyc - run_n - 1) % ROUND : 0;
                cmp_sel   = cmp_ring && cmp_p >= S + G && cmp_p < 2 * (S + G);
                if (exp_q.size() > 0) mdl_fail = exp_q.pop_front();
                check("ring_on", int'(ring_on), int'(cmp_ring));
                check("valid", int'(valid), int'(cmp_valid));
                check("sel", int'(sel), int'(cmp_sel));
                check("fail", int'(fail), int'(mdl_fail));
                if (cmp_valid) begin
                    cmp_ci = ideal_count(G, INT_NS, 1'b1);
                    cmp_ce = ideal_count(G, EXT_NS, ext_on);
                    check("count_int", int'(count_internal), cmp_ci);
                    check("count_ext", int'(count_external), cmp_ce);
                    exp_q.push_back((cmp_ci < int'(fro_min)) || (cmp_ce < int'(fro_min)));
                end
            end
        end
    end

    // long-gate instance: internal count must saturate, external reaches 200
    int n_sat, vc_sat;
    initial begin
        wait (en_sat);
        n_sat  = cyc;
        vc_sat = -1;
        for (int i = 0; i < ROUND_SAT + 20; i++) begin
            @(negedge clk);
            if (valid_sat) begin
                vc_sat = cyc;
                break;
            end
        end
        check("sat_latency", vc_sat - n_sat, ROUND_SAT);
        check("sat_count_int", int'(count_internal_sat), 255);
        check("sat_count_ext", int'(count_external_sat), 200);
        @(negedge clk);
        check("sat_fail_boundary", int'(fail_sat), 1);
        sat_done = 1'b1;
    end

    // driver / directed scenarios
    int n0, vc;
    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("post_rst_count_int", int'(count_internal), 0);
        check("post_rst_fail", int'(fail), 0);

        // two back-to-back rounds: 80/40 against 60, then against 30
        fro_min = 8'd60;
        enable  = 1'b1;
        en_sat  = 1'b1;
        run_n   = cyc;
        run_m   = BIG;
        run     = 1'b1;
        n0      = cyc;
        wait_valid(ROUND + 10, "round1_valid", vc);
        check("round1_latency", vc - n0, 433);
        check("round1_count_int", int'(count_internal), 80);
        check("round1_count_ext", int'(count_external), 40);
        @(negedge clk);
        check("round1_fail", int'(fail), 1);
        @(posedge clk);
        #2 fro_min = 8'd30;
        wait_valid(ROUND + 10, "round2_valid", vc);
        check("round2_latency", vc - n0, 866);
        check("round2_count_int", int'(count_internal), 80);
        check("round2_count_ext", int'(count_external), 40);
        @(negedge clk);
        check("round2_fail", int'(fail), 0);

        // drop enable 300 cycles into round 3 (external gate)
        wait_until(n0 + 2 * ROUND + 300);
        enable = 1'b0;
        run_m  = cyc;
        @(negedge clk);
        @(negedge clk);
        check("abort_ring_off", int'(ring_on), 0);
        wait_until(n0 + 3 * ROUND + 10);
        check("abort_count_int", int'(count_internal), 80);
        check("abort_count_ext", int'(count_external), 40);
        check("abort_fail", int'(fail), 0);

        while (!sat_done && cyc < n0 + ROUND_SAT + 100) begin
            @(posedge clk);
            #2;
        end
        en_sat = 1'b0;

        // silent external ring against a minimum of 1
        ext_on  = 1'b0;
        fro_min = 8'd1;
        @(posedge clk);
        #2;
        enable = 1'b1;
        run_n  = cyc;
        run_m  = BIG;
        n0     = cyc;
        wait_valid(ROUND + 10, "dead_ext_valid", vc);
        check("dead_ext_latency", vc - n0, 433);
        check("dead_ext_count_int", int'(count_internal), 80);
        check("dead_ext_count_ext", int'(count_external), 0);
        @(negedge clk);
        check("dead_ext_fail", int'(fail), 1);

        // reset 100 cycles into the next round's internal gate
        wait_until(n0 + ROUND + 100);
        rst = 1'b1;
        run = 1'b0;
        #1;
        check("midrst_ring_on", int'(ring_on), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_fail", int'(fail), 0);
        check("midrst_count_int", int'(count_internal), 0);
        check("midrst_count_ext", int'(count_external), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        run_n = cyc;
        run_m = BIG;
        run   = 1'b1;
        n0    = cyc;
        wait_valid(ROUND + 10, "after_rst_valid", vc);
        check("after_rst_latency", vc - n0, 433);
        check("after_rst_count_int", int'(count_internal), 80);
        check("after_rst_count_ext", int'(count_external), 0);
        @(negedge clk);
        check("after_rst_fail", int'(fail), 1);

        @(posedge clk);
        #2 enable = 1'b0;
        run_m = cyc;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
